// File: rtl/rs232_pkg.sv
// Shared constants, UART state encoding and status-word packing for the RS-232 Avalon slave.
package rs232_pkg;

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    localparam int unsigned TX_OK_BIT = 6;
    localparam int unsigned RX_OK_BIT = 7;
    localparam int unsigned OE_BIT    = 3;
    localparam int unsigned FE_BIT    = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    function automatic logic [31:0] status_word(input logic rx_ok, input logic tx_ok,
                                                input logic oe, input logic fe);
        logic [31:0] s;
        s            = '0;
        s[RX_OK_BIT] = rx_ok;
        s[TX_OK_BIT] = tx_ok;
        s[OE_BIT]    = oe;
        s[FE_BIT]    = fe;
        return s;
    endfunction

endpackage

// File: rtl/rs232_rx.sv
// UART receiver: 2-flop synchronizer, start-bit validation, LSB-first deserializer.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LP_HALF = 16'(CLKS_PER_BIT / 2 - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    uart_state_e r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_prev      <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            o_byte      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            r_sync1     <= i_rxd;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    // Edge-triggered start, so a line held low after a framing error cannot retrigger
                    if (r_prev && !r_sync2) r_state <= START;
                end
                START: begin
                    if (r_cnt == LP_HALF) begin
                        r_cnt   <= '0;
                        r_state <= r_sync2 ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (r_cnt == LP_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_idx == 3'd7) r_state <= STOP;
                        else               r_idx   <= r_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == LP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (r_sync2) begin
                            o_valid <= 1'b1;
                            o_byte  <= r_shift;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rs232_avalon_slave.sv
// Avalon-MM UART slave: RX storage, TX serializer and one-wait-state handshake.
// Define RS232_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module rs232_avalon_slave
    import rs232_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        avm_clk,
    input  logic        avm_rst_n,
    input  logic [4:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);

    logic [7:0]  w_rx_byte;
    logic        w_rx_valid;
    logic        w_rx_ferr;
    logic        w_req;
    logic        w_pop;
    logic        w_push;
    logic        w_empty;
    logic        w_full;
    logic [7:0]  w_head;
    logic        w_stat_clr;
    logic        w_tx_ready;
    logic        w_tx_load;
    logic [31:0] w_rdata;
    logic        w_unused_wdata;

    logic        r_ack;
    logic        r_rd_pop;
    logic        r_oe;
    logic        r_fe;
    logic [7:0]  r_last;
    uart_state_e r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_idx;
    logic [7:0]  r_tx_shift;

    rs232_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_clk       (avm_clk),
        .i_rst_n     (avm_rst_n),
        .i_rxd       (uart_rxd),
        .o_byte      (w_rx_byte),
        .o_valid     (w_rx_valid),
        .o_frame_err (w_rx_ferr)
    );

    assign w_req           = avs_read | avs_write;
    assign avs_waitrequest = w_req & ~r_ack;
    // Pop eligibility is latched in the request cycle so a byte landing during the ack cycle is never lost
    assign w_pop           = r_rd_pop & r_ack & avs_read;
    assign w_push          = w_rx_valid & (~w_full | w_pop);
    assign w_stat_clr      = r_ack & avs_read & (avs_address == STATUS_BASE);
    assign w_tx_ready      = (r_tx_state == IDLE);
    assign w_tx_load       = r_ack & avs_write & ~avs_read & (avs_address == TX_BASE) & w_tx_ready;
    assign w_unused_wdata  = &{1'b0, avs_writedata[31:8]};

`ifdef RS232_RX_FIFO_EN
    logic [7:0] r_mem [4];
    logic [1:0] r_wptr;
    logic [1:0] r_rptr;
    logic [2:0] r_count;

    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count == 3'd4);
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) r_rptr <= r_rptr + 2'd1;
            if (w_push) begin
                r_mem[r_wptr] <= w_rx_byte;
                r_wptr        <= r_wptr + 2'd1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end
`else
    logic [7:0] r_hold;
    logic       r_full;

    assign w_empty = ~r_full;
    assign w_full  = r_full;
    assign w_head  = r_hold;

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else if (w_push) begin
            r_hold <= w_rx_byte;
            r_full <= 1'b1;
        end else if (w_pop) begin
            r_full <= 1'b0;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            RX_BASE:     w_rdata = {24'b0, (w_empty ? r_last : w_head)};
            STATUS_BASE: w_rdata = status_word(~w_empty, w_tx_ready, r_oe, r_fe);
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            r_ack        <= 1'b0;
            r_rd_pop     <= 1'b0;
            avs_readdata <= '0;
            r_oe         <= 1'b0;
            r_fe         <= 1'b0;
            r_last       <= '0;
        end else begin
            r_ack        <= w_req & ~r_ack;
            r_rd_pop     <= avs_read & ~r_ack & (avs_address == RX_BASE) & ~w_empty;
            avs_readdata <= (avs_read & ~r_ack) ? w_rdata : '0;
            if (w_pop) r_last <= w_head;
            if (w_stat_clr) begin
                r_oe <= 1'b0;
                r_fe <= 1'b0;
            end
            if (w_rx_valid & w_full & ~w_pop) r_oe <= 1'b1;
            if (w_rx_ferr)                    r_fe <= 1'b1;
        end
    end

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            uart_txd   <= 1'b1;
        end else begin
            case (r_tx_state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    r_tx_cnt <= '0;
                    r_tx_idx <= '0;
                    if (w_tx_load) begin
                        r_tx_shift <= avs_writedata[7:0];
                        uart_txd   <= 1'b0;
                        r_tx_state <= START;
                    end
                end
                START: begin
                    if (r_tx_cnt == LP_LAST) begin
                        r_tx_cnt   <= '0;
                        uart_txd   <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_state <= DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (r_tx_cnt == LP_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_idx == 3'd7) begin
                            uart_txd   <= 1'b1;
                            r_tx_state <= STOP;
                        end else begin
                            uart_txd   <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_idx   <= r_tx_idx + 3'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (r_tx_cnt == LP_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                default: r_tx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_avalon_slave.sv
// Directed self-checking bench for rs232_avalon_slave at 16 clocks per bit.
module tb_rs232_avalon_slave;

    localparam int unsigned CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  address = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        waitreq;
    logic        rxd = 1'b1;
    logic        txd;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    rs232_avalon_slave #(.CLKS_PER_BIT(CPB)) dut (
        .avm_clk         (clk),
        .avm_rst_n       (rst_n),
        .avs_address     (address),
        .avs_read        (rd),
        .avs_readdata    (rdata),
        .avs_write       (wr),
        .avs_writedata   (wdata),
        .avs_waitrequest (waitreq),
        .uart_rxd        (rxd),
        .uart_txd        (txd)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // One Avalon access; request cycle is the cycle of the first negedge.
    task automatic av_xfer(input logic r, input logic w, input logic [4:0] a,
                           input logic [31:0] d, output logic [31:0] q);
        int n;
        n = 0;
        @(negedge clk);
        address = a; rd = r; wr = w; wdata = d;
        #1;
        check_eq("waitreq_first_cycle", 32'(waitreq), 32'd1);
        do begin
            @(negedge clk);
            n++;
        end while (waitreq && n < 10);
        check_eq("wait_cycles", 32'(n), 32'd1);
        q = rdata;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q;
        logic [9:0]  exp_bits;
        int          t0;

        repeat (4) @(negedge clk);
        check_eq("txd_in_reset", 32'(txd), 32'd1);
        check_eq("waitreq_no_req", 32'(waitreq), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("readdata_reset", rdata, 32'd0);
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("status_reset", q, 32'h40);
        check_eq("txd_idle", 32'(txd), 32'd1);

        send_frame(8'hA5, 1'b1);
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("status_rx_avail", q, 32'hC0);
        av_xfer(1'b1, 1'b0, 5'd0, 32'd0, q);
        check_eq("rx_byte_A5", q, 32'hA5);
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("status_after_pop", q, 32'h40);
        av_xfer(1'b1, 1'b0, 5'd0, 32'd0, q);
        check_eq("rx_empty_last", q, 32'hA5);
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("status_empty_read", q, 32'h40);
        av_xfer(1'b1, 1'b0, 5'd4, 32'd0, q);
        check_eq("unmapped_read", q, 32'd0);

        av_xfer(1'b1, 1'b1, 5'd4, 32'h77, q);
        check_eq("rw_collision_rdata", q, 32'd0);
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("rw_collision_no_tx", q, 32'h40);
        check_eq("rw_collision_txd", 32'(txd), 32'd1);

        exp_bits = {1'b1, 8'h3C, 1'b0};
        av_xfer(1'b0, 1'b1, 5'd4, 32'h3C, q);
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            wait_cyc(t0 + 16 * k + 8);
            check_eq($sformatf("tx_bit%0d", k), 32'(txd), 32'(exp_bits[k]));
            if (k == 1) av_xfer(1'b0, 1'b1, 5'd4, 32'hFF, q);
            if (k == 2) begin
                av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
                check_eq("status_tx_busy", q, 32'h00);
            end
        end
        wait_cyc(t0 + 158);
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("tx_ready_cycle159", q, 32'h00);
        check_eq("txd_after_frame", 32'(txd), 32'd1);
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("tx_ready_after_frame", q, 32'h40);

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
`ifdef RS232_RX_FIFO_EN
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("status_two_bytes", q, 32'hC0);
        av_xfer(1'b1, 1'b0, 5'd0, 32'd0, q);
        check_eq("fifo_first", q, 32'h11);
        av_xfer(1'b1, 1'b0, 5'd0, 32'd0, q);
        check_eq("fifo_second", q, 32'h22);
`else
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("status_overrun", q, 32'hC8);
        av_xfer(1'b1, 1'b0, 5'd0, 32'd0, q);
        check_eq("overrun_kept_first", q, 32'h11);
`endif
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("status_after_drain", q, 32'h40);

        send_frame(8'h5A, 1'b0);
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("status_framing", q, 32'h44);
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("status_fe_cleared", q, 32'h40);

        av_xfer(1'b0, 1'b1, 5'd4, 32'h55, q);
        check_eq("tx2_start_bit", 32'(txd), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("tx2_start_held", 32'(txd), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("txd_after_reset_edge", 32'(txd), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        av_xfer(1'b1, 1'b0, 5'd8, 32'd0, q);
        check_eq("status_after_mid_reset", q, 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
